// File: rtl/rs_wakeup_pkg.sv
// Shared types for the reservation-station wakeup tracker.
// Tag width is fixed here so entry and packet structs stay packed.
package rs_wakeup_pkg;

  localparam int PREG_W = 6;

  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    preg_t tag1;
    preg_t tag2;
    logic  rdy1;
    logic  rdy2;
  } rs_wakeup_entry_t;

  typedef struct packed {
    logic  valid;
    preg_t t1;
    preg_t t2;
    logic  t1_rdy;
    logic  t2_rdy;
  } rs_alloc_pkt_t;

endpackage

// File: rtl/psel_gen.sv
// Priority picker: gnt_bus[k] is the k-th lowest set bit of req.
// Rows beyond the number of set bits are zero.
module psel_gen #(
  parameter int WIDTH = 8,
  parameter int REQS  = 2
) (
  input  logic [WIDTH-1:0]           req,
  output logic [REQS-1:0][WIDTH-1:0] gnt_bus
);

  logic [WIDTH-1:0] remain;

  always_comb begin
    remain  = req;
    gnt_bus = '0;
    for (int k = 0; k < REQS; k++) begin
      gnt_bus[k] = remain & (~remain + WIDTH'(1));
      remain     = remain & ~gnt_bus[k];
    end
  end

endmodule

// File: rtl/rs_wakeup.sv
// RS readiness tracker: slot allocation, CDB wakeup,
// issue/squash release and the per-entry issue request vector.
module rs_wakeup
  import rs_wakeup_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_CDB   = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_ALLOC-1:0]              alloc_valid,
  input  logic [NUM_ALLOC-1:0][PREG_W-1:0]  alloc_t1,
  input  logic [NUM_ALLOC-1:0][PREG_W-1:0]  alloc_t2,
  input  logic [NUM_ALLOC-1:0]              alloc_t1_rdy,
  input  logic [NUM_ALLOC-1:0]              alloc_t2_rdy,
  output logic [NUM_ALLOC-1:0][DEPTH-1:0]   alloc_slot,
  input  logic [NUM_CDB-1:0]                cdb_valid,
  input  logic [NUM_CDB-1:0][PREG_W-1:0]    cdb_tag,
  input  logic [DEPTH-1:0]                  issued,
  input  logic [DEPTH-1:0]                  squash,
  output logic [DEPTH-1:0]                  inst_req,
  output logic [DEPTH-1:0]                  entry_valid,
  output logic [$clog2(DEPTH+1)-1:0]        num_free
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int RANK_W = (NUM_ALLOC > 1) ? $clog2(NUM_ALLOC) : 1;

  rs_wakeup_entry_t ent_q [DEPTH];
  rs_wakeup_entry_t ent_d [DEPTH];
  rs_alloc_pkt_t    pkt   [NUM_ALLOC];

  logic [DEPTH-1:0]                free_vec;
  logic [NUM_ALLOC-1:0][DEPTH-1:0] gnt_bus;
  logic [RANK_W-1:0]               rank;

  function automatic logic cdb_hit(preg_t tag);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_CDB; j++)
      if (cdb_valid[j] && (cdb_tag[j] == tag))
        hit = 1'b1;
    return hit;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_ALLOC; k++) begin
      pkt[k].valid  = alloc_valid[k];
      pkt[k].t1     = alloc_t1[k];
      pkt[k].t2     = alloc_t2[k];
      pkt[k].t1_rdy = alloc_t1_rdy[k];
      pkt[k].t2_rdy = alloc_t2_rdy[k];
    end
  end

  always_comb begin
    entry_valid = '0;
    inst_req    = '0;
    num_free    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ent_q[i].valid;
      inst_req[i]    = ent_q[i].valid &
                       ent_q[i].rdy1 & ent_q[i].rdy2;
      if (!ent_q[i].valid)
        num_free = num_free + CNT_W'(1);
    end
  end

  // Only registered occupancy is offered; same-cycle frees wait a cycle.
  assign free_vec = ~entry_valid;

  psel_gen #(
    .WIDTH (DEPTH),
    .REQS  (NUM_ALLOC)
  ) u_psel (
    .req     (free_vec),
    .gnt_bus (gnt_bus)
  );

  always_comb begin
    alloc_slot = '0;
    rank       = '0;
    for (int k = 0; k < NUM_ALLOC; k++) begin
      if (pkt[k].valid) begin
        alloc_slot[k] = gnt_bus[rank];
        rank          = rank + RANK_W'(1);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        if (cdb_hit(ent_q[i].tag1)) ent_d[i].rdy1 = 1'b1;
        if (cdb_hit(ent_q[i].tag2)) ent_d[i].rdy2 = 1'b1;
      end
      if (issued[i])
        ent_d[i].valid = 1'b0;
      if (squash[i]) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].rdy1  = 1'b0;
        ent_d[i].rdy2  = 1'b0;
      end
      // A granted slot was free, so the new packet wins outright.
      for (int k = 0; k < NUM_ALLOC; k++) begin
        if (alloc_slot[k][i]) begin
          ent_d[i].valid = 1'b1;
          ent_d[i].tag1  = pkt[k].t1;
          ent_d[i].tag2  = pkt[k].t2;
          ent_d[i].rdy1  = pkt[k].t1_rdy | cdb_hit(pkt[k].t1);
          ent_d[i].rdy2  = pkt[k].t2_rdy | cdb_hit(pkt[k].t2);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

  // Slots released this cycle may be counted ahead by the dispatcher.
  a_over_alloc: assert property (
    @(posedge clock) disable iff (reset)
    $countones(alloc_valid) <=
      int'(num_free) + $countones((issued | squash) & entry_valid)
  );

  a_issue_invalid: assert property (
    @(posedge clock) disable iff (reset)
    (issued & ~entry_valid) == '0
  );

endmodule

// File: tb/tb_rs_wakeup.sv
// Bench for rs_wakeup: directed scenarios plus random traffic
// compared every cycle against an array-based occupancy model.
module tb_rs_wakeup;
  import rs_wakeup_pkg::*;

  localparam int D  = 8;
  localparam int NA = 2;
  localparam int NC = 2;

  logic                        clock;
  logic                        reset;
  logic [NA-1:0]               alloc_valid;
  logic [NA-1:0][PREG_W-1:0]   alloc_t1;
  logic [NA-1:0][PREG_W-1:0]   alloc_t2;
  logic [NA-1:0]               alloc_t1_rdy;
  logic [NA-1:0]               alloc_t2_rdy;
  logic [NA-1:0][D-1:0]        alloc_slot;
  logic [NC-1:0]               cdb_valid;
  logic [NC-1:0][PREG_W-1:0]   cdb_tag;
  logic [D-1:0]                issued;
  logic [D-1:0]                squash;
  logic [D-1:0]                inst_req;
  logic [D-1:0]                entry_valid;
  logic [$clog2(D+1)-1:0]      num_free;

  rs_wakeup #(.DEPTH(D), .NUM_ALLOC(NA), .NUM_CDB(NC)) dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_t1     (alloc_t1),
    .alloc_t2     (alloc_t2),
    .alloc_t1_rdy (alloc_t1_rdy),
    .alloc_t2_rdy (alloc_t2_rdy),
    .alloc_slot   (alloc_slot),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .issued       (issued),
    .squash       (squash),
    .inst_req     (inst_req),
    .entry_valid  (entry_valid),
    .num_free     (num_free)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  bit mv [D];
  bit mr1 [D];
  bit mr2 [D];
  int mt1 [D];
  int mt2 [D];
  logic [D-1:0] exp_slot [NA];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_free();
    int n = 0;
    for (int i = 0; i < D; i++) if (!mv[i]) n++;
    return n;
  endfunction

  function automatic logic [D-1:0] m_valid();
    logic [D-1:0] v = '0;
    for (int i = 0; i < D; i++) v[i] = mv[i];
    return v;
  endfunction

  function automatic logic [D-1:0] m_req();
    logic [D-1:0] v = '0;
    for (int i = 0; i < D; i++) v[i] = mv[i] && mr1[i] && mr2[i];
    return v;
  endfunction

  function automatic bit m_hit(int tag);
    for (int j = 0; j < NC; j++)
      if (cdb_valid[j] && int'(cdb_tag[j]) == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Free list in ascending order, handed out to requesting lanes in order.
  function automatic void m_grant();
    int q[$];
    for (int i = 0; i < D; i++) if (!mv[i]) q.push_back(i);
    for (int k = 0; k < NA; k++) begin
      exp_slot[k] = '0;
      if (alloc_valid[k] && q.size() > 0)
        exp_slot[k] = D'(1) << q.pop_front();
    end
  endfunction

  function automatic void m_edge();
    if (reset) begin
      for (int i = 0; i < D; i++) begin
        mv[i] = 0; mr1[i] = 0; mr2[i] = 0; mt1[i] = 0; mt2[i] = 0;
      end
      return;
    end
    for (int i = 0; i < D; i++) if (mv[i]) begin
      if (m_hit(mt1[i])) mr1[i] = 1;
      if (m_hit(mt2[i])) mr2[i] = 1;
    end
    for (int i = 0; i < D; i++) begin
      if (issued[i]) mv[i] = 0;
      if (squash[i]) begin mv[i] = 0; mr1[i] = 0; mr2[i] = 0; end
    end
    for (int k = 0; k < NA; k++)
      for (int i = 0; i < D; i++) if (exp_slot[k][i]) begin
        mv[i]  = 1;
        mt1[i] = int'(alloc_t1[k]);
        mt2[i] = int'(alloc_t2[k]);
        mr1[i] = alloc_t1_rdy[k] || m_hit(mt1[i]);
        mr2[i] = alloc_t2_rdy[k] || m_hit(mt2[i]);
      end
  endfunction

  task automatic idle();
    alloc_valid = '0; alloc_t1 = '0; alloc_t2 = '0;
    alloc_t1_rdy = '0; alloc_t2_rdy = '0;
    cdb_valid = '0; cdb_tag = '0;
    issued = '0; squash = '0;
  endtask

  task automatic lane(int k, int t1, bit r1, int t2, bit r2);
    alloc_valid[k]  = 1'b1;
    alloc_t1[k]     = PREG_W'(t1);
    alloc_t2[k]     = PREG_W'(t2);
    alloc_t1_rdy[k] = r1;
    alloc_t2_rdy[k] = r2;
  endtask

  task automatic tick();
    #1;
    m_grant();
    for (int k = 0; k < NA; k++)
      chk($sformatf("alloc_slot%0d", k), alloc_slot[k], exp_slot[k]);
    chk("entry_valid", entry_valid, m_valid());
    chk("inst_req", inst_req, m_req());
    chk("num_free", num_free, m_free());
    m_edge();
    @(negedge clock);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    for (int i = 0; i < D; i++) begin
      mv[i] = 0; mr1[i] = 0; mr2[i] = 0; mt1[i] = 0; mt2[i] = 0;
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_valid", entry_valid, 8'h00);
    chk("rst_req", inst_req, 8'h00);
    chk("rst_free", num_free, 4'd8);

    lane(0, 5, 1, 7, 0);
    lane(1, 3, 1, 3, 1);
    #1;
    chk("d1_slot0", alloc_slot[0], 8'h01);
    chk("d1_slot1", alloc_slot[1], 8'h02);
    tick();
    idle();
    #1;
    chk("d1_valid", entry_valid, 8'h03);
    chk("d1_req", inst_req, 8'h02);
    chk("d1_free", num_free, 4'd6);

    cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd7;
    #1;
    chk("cdb_same_cycle", inst_req, 8'h02);
    tick();
    idle();
    #1;
    chk("cdb_next_cycle", inst_req, 8'h03);

    lane(0, 9, 0, 9, 0);
    cdb_valid[1] = 1'b1; cdb_tag[1] = 6'd9;
    tick();
    idle();
    #1;
    chk("alloc_cdb_hit", inst_req, 8'h07);

    lane(0, 20, 0, 21, 0); lane(1, 22, 0, 23, 1);
    tick(); idle();
    lane(0, 24, 1, 25, 0); lane(1, 26, 0, 27, 0);
    tick(); idle();
    lane(0, 28, 0, 29, 0);
    tick(); idle();
    #1;
    chk("full_valid", entry_valid, 8'hFF);
    issued = 8'h81;
    lane(0, 30, 1, 31, 1);
    #1;
    chk("full_no_slot", alloc_slot[0], 8'h00);
    tick(); idle();
    lane(0, 30, 1, 31, 1);
    #1;
    chk("refree_cnt", num_free, 4'd2);
    chk("refree_slot", alloc_slot[0], 8'h01);
    tick(); idle();

    reset = 1'b1;
    tick();
    reset = 1'b0; idle();
    for (int c = 0; c < 3; c++) begin
      lane(0, 40 + 2*c, 0, 50 + 2*c, 1);
      if (c < 2) lane(1, 41 + 2*c, 0, 51 + 2*c, 1);
      tick(); idle();
    end
    #1;
    chk("sq_pre_valid", entry_valid, 8'h1F);
    squash = 8'h14;
    cdb_valid = 2'b11; cdb_tag[0] = 6'd42; cdb_tag[1] = 6'd44;
    tick(); idle();
    #1;
    chk("sq_valid", entry_valid, 8'h0B);
    chk("sq_req", inst_req, 8'h00);
    chk("sq_free", num_free, 4'd5);
    lane(0, 1, 1, 2, 1); lane(1, 3, 0, 4, 1);
    tick(); idle();

    reset = 1'b1;
    lane(0, 11, 1, 12, 1); lane(1, 13, 1, 14, 1);
    cdb_valid[0] = 1'b1; cdb_tag[0] = 6'd3;
    issued = 8'h01;
    tick();
    reset = 1'b0; idle();
    #1;
    chk("mid_rst_valid", entry_valid, 8'h00);
    chk("mid_rst_req", inst_req, 8'h00);
    chk("mid_rst_free", num_free, 4'd8);

    for (int c = 0; c < 3000; c++) begin
      int nf, taken;
      logic [D-1:0] mvv;
      idle();
      nf = m_free();
      taken = 0;
      mvv = m_valid();
      for (int k = 0; k < NA; k++) begin
        if ($urandom_range(2, 0) != 0 && taken < nf) begin
          lane(k, $urandom_range(15, 0), $urandom_range(1, 0),
               $urandom_range(15, 0), $urandom_range(1, 0));
          taken++;
        end
      end
      for (int j = 0; j < NC; j++) begin
        cdb_valid[j] = $urandom_range(1, 0);
        cdb_tag[j]   = PREG_W'($urandom_range(15, 0));
      end
      issued = D'($urandom) & D'($urandom) & mvv;
      for (int i = 0; i < D; i++)
        squash[i] = mvv[i] && ($urandom_range(7, 0) == 0);
      reset = ($urandom_range(199, 0) == 0);
      tick();
      reset = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
